// File: rtl/sample_decimate_boxcar.sv
// Boxcar decimator: sums every RATIO accepted samples into one full-precision
// output word and presents it on a valid/ready handshake. A 1-in-RATIO
// zero-stuffed stream is recovered exactly; other streams are band-limited.
module sample_decimate_boxcar #(
    parameter int DATA_W = 32,
    parameter int RATIO  = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W+3-1:0]         out_data,
    output logic                        frame_start,
    output logic                        ovf
);

    // Three guard bits hold the exact sum of up to eight full-scale samples.
    localparam int ACC_W = DATA_W + 3;
    localparam int PH_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(RATIO - 1);

    logic [ACC_W-1:0] acc;
    logic [PH_W-1:0]  phase;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] sum;
    logic             frame_end;

    // Sign-extend the sample and form the running sum including it.
    assign in_ext    = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};
    assign sum       = acc + in_ext;
    assign frame_end = in_valid && (phase == LAST_PHASE);

    // Phase/accumulator update, result hand-off and overflow tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            phase       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            frame_start <= 1'b0;
            ovf         <= 1'b0;
        end else if (clr) begin
            // The sample presented alongside clr is discarded; out_data keeps
            // its stale value since out_valid already marks it undelivered.
            acc         <= '0;
            phase       <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            frame_start <= in_valid && (phase == '0);

            if (in_valid) begin
                if (phase == LAST_PHASE) begin
                    acc   <= '0;
                    phase <= '0;
                end else begin
                    acc   <= sum;
                    phase <= phase + PH_W'(1);
                end
            end

            // A frame end during a handshake replaces the word with no bubble;
            // a frame end against a stalled word loses the new result.
            if (frame_end) begin
                if (!out_valid || out_ready) begin
                    out_data  <= sum;
                    out_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_decimate_boxcar.sv
// Scoreboard bench for sample_decimate_boxcar (DATA_W=32, RATIO=6).
// Expected sums are queued when a frame is issued; a negedge monitor pops and
// compares on every out_valid && out_ready handshake.
module tb_sample_decimate_boxcar;

    localparam int DATA_W = 32;
    localparam int RATIO  = 6;
    localparam int ACC_W  = DATA_W + 3;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              frame_start;
    logic              ovf;

    logic [ACC_W-1:0]  exp_q[$];
    int                checks;
    int                passed;

    sample_decimate_boxcar #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .frame_start (frame_start),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present one sample for one cycle; returns 1 time unit after the accepting edge.
    task automatic send(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every delivered word must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got %0h expected no output", out_data);
            end else begin
                chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int gaps[6] = '{0, 3, 1, 2, 0, 3};
        checks    = 0;
        passed    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset values.
        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_frame_start", 64'(frame_start), 0);
        chk("rst_ovf", 64'(ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Build a pending word and a fresh frame_start, then reset mid-frame.
        out_ready = 1'b0;
        repeat (RATIO) send(32'd1);
        chk("pre_rst_valid", 64'(out_valid), 1);
        chk("pre_rst_data", 64'(out_data), 6);
        send(32'd9);
        chk("pre_rst_frame_start", 64'(frame_start), 1);
        in_valid = 1'b1;
        in_data  = 32'd9;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 0);
        chk("async_rst_out_data", 64'(out_data), 0);
        chk("async_rst_frame_start", 64'(frame_start), 0);
        chk("async_rst_ovf", 64'(ovf), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(35'd6);
        repeat (RATIO) send(32'd1);
        chk("post_rst_latency", 64'(out_valid), 1);

        // Zero-stuffed recovery.
        exp_q.push_back(35'd100);
        exp_q.push_back(35'h7_FFFF_FFF9);
        for (int i = 0; i < 12; i++) begin
            logic [DATA_W-1:0] v;
            v = (i == 0) ? 32'd100 : (i == 6) ? 32'hFFFF_FFF9 : 32'd0;
            send(v);
            if (i == 0 || i == 6) chk("zs_frame_start", 64'(frame_start), 1);
            if (i == 1) chk("zs_frame_start_low", 64'(frame_start), 0);
            if (i == 4) chk("zs_valid_early", 64'(out_valid), 0);
            if (i == 5) chk("zs_valid_latency", 64'(out_valid), 1);
        end
        idle(1);

        // Full scale, both polarities, back to back.
        exp_q.push_back(35'h2_FFFF_FFFA);
        exp_q.push_back(35'h5_0000_0000);
        repeat (RATIO) send(32'h7FFF_FFFF);
        repeat (RATIO) send(32'h8000_0000);
        idle(2);

        // Gapped input: idle cycles add nothing and only delay the frame.
        exp_q.push_back(35'd21);
        for (int i = 0; i < RATIO; i++) begin
            if (i == 5) chk("gap_valid_before_last", 64'(out_valid), 0);
            send(DATA_W'(i + 1));
            if (i == 5) chk("gap_valid_latency", 64'(out_valid), 1);
            if (gaps[i] > 0) idle(gaps[i]);
        end
        idle(2);

        // Backpressure across two frames; the second result is lost.
        out_ready = 1'b0;
        exp_q.push_back(35'd6);
        repeat (RATIO) send(32'd1);
        chk("bp_valid", 64'(out_valid), 1);
        chk("bp_data", 64'(out_data), 6);
        repeat (RATIO - 1) send(32'd2);
        chk("bp_ovf_early", 64'(ovf), 0);
        send(32'd2);
        chk("bp_ovf_set", 64'(ovf), 1);
        chk("bp_data_held", 64'(out_data), 6);
        chk("bp_valid_held", 64'(out_valid), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_fall", 64'(out_valid), 0);
        chk("bp_ovf_sticky", 64'(ovf), 1);

        // clr drops a pending word and a partial frame, and clears ovf.
        out_ready = 1'b0;
        repeat (RATIO) send(32'd3);
        chk("clr_pending_valid", 64'(out_valid), 1);
        repeat (3) send(32'd5);
        clr = 1'b1;
        send(32'd5);
        clr = 1'b0;
        chk("clr_ovf", 64'(ovf), 0);
        chk("clr_out_valid", 64'(out_valid), 0);
        chk("clr_frame_start", 64'(frame_start), 0);
        out_ready = 1'b1;
        exp_q.push_back(35'd12);
        repeat (RATIO) send(32'd2);
        idle(3);

        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
